// File: rtl/rocc_cmd_frontend.sv
// rocc_cmd_frontend: accepts RoCC commands, issues them to the interpreter, times execution and returns the cycle count.
module rocc_cmd_frontend #(
  parameter int XLEN     = 64,
  parameter int OFFSET_W = 32,
  parameter int SIZE_W   = 32,
  parameter int FUNCT_W  = 7,
  parameter int CNT_W    = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [FUNCT_W-1:0]  cmd_funct,
  input  logic [4:0]          cmd_rd,
  input  logic [XLEN-1:0]     cmd_rs1,
  input  logic [XLEN-1:0]     cmd_rs2,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [4:0]          resp_rd,
  output logic [XLEN-1:0]     resp_data,
  output logic                busy,
  output logic [OFFSET_W-1:0] rocc_if_dram_offset,
  output logic [SIZE_W-1:0]   rocc_if_size,
  output logic [FUNCT_W-1:0]  rocc_if_funct,
  output logic                rocc_if_cmd_vld,
  input  logic                rocc_if_fin,
  input  logic                rocc_if_busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, RUN, RESP} state_t;
  state_t state_q, state_d;
  logic [FUNCT_W-1:0]  funct_q, funct_d;
  logic [4:0]          rd_q, rd_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [XLEN-1:0]     resp_data_q, resp_data_d;
  logic                cmd_vld_q, cmd_vld_d, resp_valid_q, resp_valid_d;
  logic                unused_hi;
  assign unused_hi = ^{cmd_rs1[XLEN-1:OFFSET_W], cmd_rs2[XLEN-1:SIZE_W]};
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  always_comb begin
    state_d     = state_q;
    funct_d     = funct_q;
    rd_d        = rd_q;
    offset_d    = offset_q;
    size_d      = size_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    cmd_vld_d   = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        funct_d     = cmd_funct;
        rd_d        = cmd_rd;
        offset_d    = cmd_rs1[OFFSET_W-1:0];
        size_d      = cmd_rs2[SIZE_W-1:0];
        cnt_d       = '0;
        resp_data_d = '0;
        state_d     = (cmd_rs2[SIZE_W-1:0] == '0) ? RESP : ISSUE;
      end
      ISSUE: if (!rocc_if_busy) begin
        cmd_vld_d = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        cnt_d = cnt_inc;
        if (rocc_if_fin) begin
          resp_data_d = XLEN'(cnt_inc);
          state_d     = RESP;
        end
      end
      default: state_d = resp_ready ? IDLE : RESP;
    endcase
    resp_valid_d = state_d == RESP;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      funct_q      <= '0;
      rd_q         <= '0;
      offset_q     <= '0;
      size_q       <= '0;
      cnt_q        <= '0;
      resp_data_q  <= '0;
      cmd_vld_q    <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      funct_q      <= funct_d;
      rd_q         <= rd_d;
      offset_q     <= offset_d;
      size_q       <= size_d;
      cnt_q        <= cnt_d;
      resp_data_q  <= resp_data_d;
      cmd_vld_q    <= cmd_vld_d;
      resp_valid_q <= resp_valid_d;
    end
  end
  assign cmd_ready           = state_q == IDLE;
  assign busy                = state_q != IDLE;
  assign resp_valid          = resp_valid_q;
  assign resp_rd             = rd_q;
  assign resp_data           = resp_data_q;
  assign rocc_if_dram_offset = offset_q;
  assign rocc_if_size        = size_q;
  assign rocc_if_funct       = funct_q;
  assign rocc_if_cmd_vld     = cmd_vld_q;
endmodule
